alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that owns the processor accumulator and sequences the shared 8-bit ALU (select lines s1/s0; s0=0 passes inp1, s0=1 adds inp1+inp2).
- Accepts commands over a valid/ready handshake and drives the ALU inputs.
- Captures the ALU result into the accumulator and returns it over a valid/ready response channel.
- Builds MUL from repeated ALU additions.

Parameters:
- WIDTH, 8, datapath width of accumulator, operand and ALU ports.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 LOAD, 01 ADD, 10 MUL, 11 CLR.
- cmd_data  input  WIDTH  operand.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  WIDTH  accumulator value after the command.
- rsp_ovf  output  1  unsigned carry-out occurred during the command.
- busy  output  1  command in progress (state not IDLE).
- alu_s1  output  1  ALU select bit 1; reserved, always 0.
- alu_s0  output  1  ALU select bit 0.
- alu_inp1  output  WIDTH  ALU operand 1.
- alu_inp2  output  WIDTH  ALU operand 2.
- alu_out  input  WIDTH  ALU result (combinational from the ALU).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; acc, op_q, opnd_q, count, ovf all 0.
- Outputs in reset: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ovf=0, busy=0, alu_s1=0, alu_s0=0, alu_inp1=0, alu_inp2=0.
- Reset mid-command aborts the command; no response is produced.
- cmd_ready = (state==IDLE). rsp_valid = (state==DONE). rsp_data = acc. rsp_ovf = ovf.
- Default ALU drive (IDLE, DONE): s0=0, inp1=acc, inp2=0.
- IDLE:
  - On cmd_valid&&cmd_ready: latch cmd_op into op_q and cmd_data into opnd_q; clear ovf; go to EXEC.
- EXEC (one cycle):
  - LOAD: s0=0, inp1=opnd_q; acc<=alu_out; go to DONE.
  - ADD: s0=1, inp1=acc, inp2=opnd_q; acc<=alu_out; ovf<=(alu_out<acc); go to DONE.
  - CLR: acc<=0; go to DONE.
  - MUL: base<=acc, acc<=0, count<=opnd_q.
  - MUL with opnd_q==0: go to DONE with acc=0, ovf=0. Otherwise go to MULT.
- MULT:
  - s0=1, inp1=acc, inp2=base; acc<=alu_out; ovf<=ovf|(alu_out<acc); count<=count-1.
  - When count==1, go to DONE.
  - Result is acc*operand mod 2^WIDTH. ovf is sticky, set on any intermediate carry.
- DONE:
  - Hold rsp_data and rsp_ovf stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, go to IDLE. A new command is accepted no earlier than the next cycle.
- Latency, handshake cycle T to first rsp_valid cycle:
  - LOAD/ADD/CLR: T+2.
  - MUL n≥1: T+n+2.
  - MUL 0: T+2.
- Overflow is detected locally by unsigned wrap compare; the ALU has no carry output.
- cmd_valid while not IDLE is ignored; no queueing.
- Accumulator persists across commands; only CLR, LOAD, MUL and reset overwrite it.

Optional Feature:
- Macro: ALU_SEQUENCER_MUL_EN.
- Defined: MUL implemented as described, including the MULT state, count and base registers.
- Undefined: MULT state, count and base are not built. Op 10 behaves as a NOP: EXEC goes straight to DONE with acc unchanged and rsp_ovf=0. Latency is T+2.

Test Plan:
- Reset, LOAD 0x2A accepted at T -> rsp_valid at T+2, rsp_data=0x2A, rsp_ovf=0, busy=1 during T+1..T+2.
- LOAD 0xF0, then ADD 0x20 -> rsp_data=0x10, rsp_ovf=1. Then ADD 0x05 -> rsp_data=0x15, rsp_ovf=0.
- LOAD 5, MUL 7 (MUL_EN defined) -> rsp_valid at T+9, rsp_data=0x23, rsp_ovf=0. alu_s0=1 for exactly 7 cycles.
- LOAD 0x10, MUL 0x11 -> rsp_data=0x10, rsp_ovf=1. LOAD 9, MUL 0 -> rsp_data=0x00 at T+2.
- LOAD 0x33 with rsp_ready held low 5 cycles, cmd_valid held high with ADD 1:
  - rsp_valid and rsp_data=0x33 stay stable; cmd_ready=0; the ADD is not accepted until the cycle after rsp_ready.
  - The ADD then returns 0x34.
- LOAD 4, MUL 200, assert reset 3 cycles into MULT -> all outputs at reset values immediately, no response. Then ADD 3 -> rsp_data=0x03.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a requester and alu_sequencer.
// The master drives commands and accepts responses; the slave is the sequencer.
interface alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_ovf
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_ovf
    );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator controller that sequences an external 8-bit pass/add ALU.
// Define ALU_SEQUENCER_MUL_EN to build MUL as repeated additions; otherwise op 10 is a NOP.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    alu_sequencer_if.slave   bus,
    output logic             busy,
    output logic             alu_s1,
    output logic             alu_s0,
    output logic [WIDTH-1:0] alu_inp1,
    output logic [WIDTH-1:0] alu_inp2,
    input  logic [WIDTH-1:0] alu_out
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

`ifdef ALU_SEQUENCER_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MULT = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             ovf_q, ovf_d;
`ifdef ALU_SEQUENCER_MUL_EN
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] base_q, base_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ALU_SEQUENCER_MUL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            base_q  <= '0;
        end else begin
            count_q <= count_d;
            base_q  <= base_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        ovf_d    = ovf_q;
`ifdef ALU_SEQUENCER_MUL_EN
        count_d  = count_q;
        base_d   = base_q;
`endif
        alu_s0   = 1'b0;
        alu_inp1 = acc_q;
        alu_inp2 = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    opnd_d  = bus.cmd_data;
                    ovf_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_DONE;
                case (op_q)
                    OP_LOAD: begin
                        alu_inp1 = opnd_q;
                        acc_d    = alu_out;
                    end
                    OP_ADD: begin
                        alu_s0   = 1'b1;
                        alu_inp2 = opnd_q;
                        acc_d    = alu_out;
                        // The ALU has no carry-out, so a wrapped sum is smaller than acc.
                        ovf_d    = (alu_out < acc_q);
                    end
                    OP_MUL: begin
`ifdef ALU_SEQUENCER_MUL_EN
                        base_d  = acc_q;
                        acc_d   = '0;
                        count_d = opnd_q;
                        state_d = (opnd_q == '0) ? S_DONE : S_MULT;
`endif
                    end
                    OP_CLR: begin
                        acc_d = '0;
                    end
                    default: ;
                endcase
            end

`ifdef ALU_SEQUENCER_MUL_EN
            S_MULT: begin
                alu_s0   = 1'b1;
                alu_inp1 = acc_q;
                alu_inp2 = base_q;
                acc_d    = alu_out;
                ovf_d    = ovf_q | (alu_out < acc_q);
                count_d  = count_q - WIDTH'(1);
                if (count_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_data  = acc_q;
    assign bus.rsp_ovf   = ovf_q;
    assign busy          = (state_q != S_IDLE);
    assign alu_s1        = 1'b0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random commands
// checked against an arithmetic model of the accumulator.
`timescale 1ns/1ps
module tb_alu_sequencer;
    localparam int WIDTH = 8;
`ifdef ALU_SEQUENCER_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             busy, alu_s1, alu_s0;
    logic [WIDTH-1:0] alu_inp1, alu_inp2, alu_out;

    alu_sequencer_if #(.WIDTH(WIDTH)) bus();

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .alu_s1   (alu_s1),
        .alu_s0   (alu_s0),
        .alu_inp1 (alu_inp1),
        .alu_inp2 (alu_inp2),
        .alu_out  (alu_out)
    );

    always #5 clk = ~clk;

    // Shared ALU: s0=0 passes inp1, s0=1 adds.
    assign alu_out = alu_s0 ? alu_inp1 + alu_inp2 : alu_inp1;

    int checks = 0;
    int errors = 0;
    int acc_m  = 0;

    // Reference: accumulator arithmetic on plain integers.
    task automatic model(input int op, input int d, output int data, output int ovf,
                         output int lat, output int s0n);
        int r;
        ovf = 0; lat = 2; s0n = 0;
        case (op)
            0: acc_m = d;
            1: begin r = acc_m + d; ovf = int'(r > 255); acc_m = r % 256; s0n = 1; end
            2: if (MUL_EN) begin
                   r = acc_m * d; ovf = int'(r > 255); acc_m = r % 256;
                   s0n = d; lat = (d == 0) ? 2 : d + 2;
               end
            default: acc_m = 0;
        endcase
        data = acc_m;
    endtask

    // Issues one command, observes latency, ALU adds, stability and release; no comparisons.
    task automatic run_cmd(input int op, input int d, input int hold,
                           output int data, output int ovf, output int lat, output int s0n,
                           output int busy_bad, output int stable_bad, output int to);
        int w;
        int opv, dv;
        logic [1:0]       op2;
        logic [WIDTH-1:0] d8;
        opv = op; dv = d;
        op2 = opv[1:0]; d8 = dv[WIDTH-1:0];
        to = 0; busy_bad = 0; stable_bad = 0; s0n = 0; w = 0;
        @(negedge clk);
        while (!bus.cmd_ready && w < 1000) begin @(negedge clk); w++; end
        if (!bus.cmd_ready) to = 1;
        bus.cmd_valid = 1'b1; bus.cmd_op = op2; bus.cmd_data = d8;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 1000) begin
            if (alu_s0) s0n++;
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) to = 1;
        if (busy !== 1'b1) busy_bad++;
        data = int'(bus.rsp_data);
        ovf  = int'(bus.rsp_ovf);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
                int'(bus.rsp_data) != data || int'(bus.rsp_ovf) != ovf) stable_bad++;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) busy_bad++;
        $display("txn op=%0d data=%02h -> rsp=%02h ovf=%0d lat=%0d s0=%0d", op, d, data, ovf, lat, s0n);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", bus.rsp_data); end
        checks++; if (bus.rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf: got %b want 0", bus.rsp_ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({alu_s1, alu_s0} !== 2'b00) begin errors++; $display("FAIL reset_alu_sel: got %b want 00", {alu_s1, alu_s0}); end
        checks++; if (alu_inp1 !== 8'h00 || alu_inp2 !== 8'h00) begin errors++; $display("FAIL reset_alu_inp: got %h/%h want 00/00", alu_inp1, alu_inp2); end
        reset = 1'b0;
        acc_m = 0;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: ready=%b busy=%b want 1/0", bus.cmd_ready, busy); end
    endtask

    // Runs a list of commands, comparing every response against the model.
    task automatic check_cmd(input string name, input int op, input int d, input int hold);
        int ed, eo, el, es, ad, ao, al, as, bb, sb, to;
        model(op, d, ed, eo, el, es);
        run_cmd(op, d, hold, ad, ao, al, as, bb, sb, to);
        checks++; if (to != 0) begin errors++; $display("FAIL %s_timeout: got timeout=%0d want 0", name, to); end
        checks++; if (ad != ed) begin errors++; $display("FAIL %s_data: got %02h want %02h", name, ad, ed); end
        checks++; if (ao != eo) begin errors++; $display("FAIL %s_ovf: got %0d want %0d", name, ao, eo); end
        checks++; if (al != el) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, al, el); end
        checks++; if (as != es) begin errors++; $display("FAIL %s_s0_cycles: got %0d want %0d", name, as, es); end
        checks++; if (bb != 0) begin errors++; $display("FAIL %s_busy_ready: got %0d bad cycles want 0", name, bb); end
        checks++; if (sb != 0) begin errors++; $display("FAIL %s_hold_stable: got %0d bad cycles want 0", name, sb); end
    endtask

    task automatic test_load;
        check_cmd("load_2a", 0, 8'h2A, 0);
    endtask

    task automatic test_add_ovf;
        check_cmd("load_f0", 0, 8'hF0, 0);
        check_cmd("add_20", 1, 8'h20, 1);
        check_cmd("add_05", 1, 8'h05, 0);
        check_cmd("clr", 3, 8'h77, 0);
    endtask

    task automatic test_mul;
        check_cmd("load_5", 0, 5, 0);
        check_cmd("mul_7", 2, 7, 0);
        check_cmd("load_10", 0, 8'h10, 0);
        check_cmd("mul_11", 2, 8'h11, 2);
        check_cmd("load_9", 0, 9, 0);
        check_cmd("mul_0", 2, 0, 0);
    endtask

    task automatic test_back_to_back;
        check_cmd("load_33", 0, 8'h33, 0);
        check_cmd("clr_pre", 3, 0, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_data = 8'h33;
        @(negedge clk);
        bus.cmd_op = 2'b01; bus.cmd_data = 8'h01;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h33) begin errors++; $display("FAIL b2b_first_rsp: got v=%b d=%h want 1/33", bus.rsp_valid, bus.rsp_data); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h33 || bus.cmd_ready !== 1'b0)
                begin errors++; $display("FAIL b2b_hold_%0d: got v=%b d=%h rdy=%b want 1/33/0", i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready); end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_not_early: got rdy=%b busy=%b want 1/0", bus.cmd_ready, busy); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b rdy=%b want 1/0", busy, bus.cmd_ready); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h34 || bus.rsp_ovf !== 1'b0) begin errors++; $display("FAIL b2b_add_rsp: got v=%b d=%h o=%b want 1/34/0", bus.rsp_valid, bus.rsp_data, bus.rsp_ovf); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        acc_m = 8'h34;
        $display("txn b2b load=33 add=01 -> rsp=%02h", bus.rsp_data);
    endtask

    task automatic test_reset_abort;
        int seen;
        check_cmd("load_4", 0, 4, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_data = 8'd200;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got rdy=%b v=%b busy=%b want 1/0/0", bus.cmd_ready, bus.rsp_valid, busy); end
        checks++; if (bus.rsp_data !== 8'h00 || bus.rsp_ovf !== 1'b0) begin errors++; $display("FAIL abort_rsp: got d=%h o=%b want 00/0", bus.rsp_data, bus.rsp_ovf); end
        checks++; if (alu_s0 !== 1'b0 || alu_inp1 !== 8'h00 || alu_inp2 !== 8'h00) begin errors++; $display("FAIL abort_alu: got s0=%b %h/%h want 0 00/00", alu_s0, alu_inp1, alu_inp2); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        acc_m = 0;
        seen = 0;
        repeat (4) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_rsp: got %0d rsp cycles want 0", seen); end
        $display("txn reset during MUL 200 -> aborted");
        check_cmd("add_3", 1, 3, 0);
    endtask

    task automatic test_random;
        int op, d, hold;
        for (int n = 0; n < 30; n++) begin
            op   = int'($urandom_range(0, 3));
            d    = (op == 2) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
            if (op == 2 && $urandom_range(0, 3) == 0) d = int'($urandom_range(0, 255));
            hold = int'($urandom_range(0, 3));
            check_cmd("random", op, d, hold);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_load();
        test_add_ovf();
        test_mul();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
